// File: rtl/fifo_arb_pkg.sv
// Shared FSM state encoding and width helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = IDLE,
        ST_GRANT = GRANT
    } state_t;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_MAX_BURST = 4;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned max_burst);
        return $clog2(max_burst + 1);
    endfunction

    localparam int unsigned DEF_IDX_W = idx_w(DEF_NUM_REQ);
    localparam int unsigned DEF_CNT_W = cnt_w(DEF_MAX_BURST);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester searching upward from last+1.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    // The final iteration revisits 'last', so it wins only as the sole requester.
    always_comb begin
        logic [IDX_W-1:0] cand;
        valid  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(last) + i) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of an async FIFO write port.
// Define FIFO_WR_ARB_BURST_EN for up to MAX_BURST beats per grant; otherwise one beat per grant.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                            wr_clk,
    input  logic                            wr_rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              ack,
    input  logic                            fifo_full,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy
);

    localparam int unsigned IDX_W = idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ out of range");
    end
    if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_max_burst
        $error("MAX_BURST out of range");
    end

    state_t           state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] pick_last;
    logic [IDX_W-1:0] pick_id;
    logic             pick_valid;
    logic             own_req;
    logic             beat;
    logic             burst_done;
    logic             release_grant;

    assign own_req = req[grant_id];
    // Gating on wr_rst keeps a reset cycle from emitting a partial beat.
    assign beat    = wr_rst && (state == ST_GRANT) && own_req && !fifo_full;

`ifdef FIFO_WR_ARB_BURST_EN
    localparam int unsigned CNT_W = cnt_w(MAX_BURST);
    logic [CNT_W-1:0] beat_cnt;

    assign burst_done = (beat_cnt == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge wr_clk) begin
        if (!wr_rst || release_grant) begin
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end
`else
    assign burst_done = 1'b1;
`endif

    assign release_grant = (state == ST_GRANT) && (!own_req || (beat && burst_done));
    assign pick_last     = (state == ST_IDLE) ? last_grant : grant_id;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req),
        .last   (pick_last),
        .valid  (pick_valid),
        .winner (pick_id)
    );

    always_ff @(posedge wr_clk) begin
        if (!wr_rst) begin
            state      <= ST_IDLE;
            grant_id   <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_id;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_grant) begin
                        last_grant <= grant_id;
                        if (pick_valid) begin
                            grant_id <= pick_id;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign fifo_wr_en   = beat;
    assign ack          = beat ? (NUM_REQ'(1) << grant_id) : '0;
    assign fifo_wr_data = req_data[32'(grant_id) * DATA_WIDTH +: DATA_WIDTH];
    assign busy         = (state == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; expectations follow FIFO_WR_ARB_BURST_EN (4 beats) or per-beat mode.
module tb_fifo_wr_arbiter;

`ifdef FIFO_WR_ARB_BURST_EN
    localparam int B = 4;
`else
    localparam int B = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        full;
    logic [3:0]  ack;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] obs;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .wr_clk       (clk),
        .wr_rst       (rst),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .fifo_full    (full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    assign obs = {busy, fifo_wr_en, ack, grant_id, fifo_wr_data};

    // Expected {busy, wr_en, ack, grant_id, data}; data is the owner's slice of 32'hD3C2B1A0.
    function automatic logic [15:0] ev(input logic b, input logic en, input logic [1:0] g);
        logic [31:0] d;
        logic [3:0]  a;
        d = 32'hD3C2B1A0;
        a = en ? (4'b0001 << g) : 4'b0000;
        return {b, en, a, g, d[32'(g)*8 +: 8]};
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst  = 1'b0;
        req  = 4'b0000;
        full = 1'b0;
        cyc();
        rst  = 1'b1;
    endtask

    task automatic test_reset;
        rst  = 1'b0;
        req  = 4'b1111;
        full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            total++;
            if (obs !== ev(1'b0, 1'b0, 2'd0))
                $display("FAIL reset cycle %0d: got %h expected %h", i, obs, ev(1'b0, 1'b0, 2'd0));
            else passed++;
        end
        #1;
    endtask

    task automatic test_burst_sole;
        do_reset();
        req = 4'b0001;
        #1;
        total++;
        if (obs !== ev(1'b0, 1'b0, 2'd0))
            $display("FAIL sole idle: got %h expected %h", obs, ev(1'b0, 1'b0, 2'd0));
        else passed++;
        cyc();
        for (int k = 0; k < B + 1; k++) begin
            #1;
            total++;
            if (obs !== ev(1'b1, 1'b1, 2'd0))
                $display("FAIL sole beat %0d: got %h expected %h", k, obs, ev(1'b1, 1'b1, 2'd0));
            else passed++;
            cyc();
        end
        req = 4'b0000;
        #1;
        total++;
        if (obs !== ev(1'b1, 1'b0, 2'd0))
            $display("FAIL sole drop: got %h expected %h", obs, ev(1'b1, 1'b0, 2'd0));
        else passed++;
        cyc();
        #1;
        total++;
        if (obs !== ev(1'b0, 1'b0, 2'd0))
            $display("FAIL sole back to idle: got %h expected %h", obs, ev(1'b0, 1'b0, 2'd0));
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [1:0] owner;
        do_reset();
        req = 4'b0011;
        #1;
        total++;
        if (obs !== ev(1'b0, 1'b0, 2'd0))
            $display("FAIL b2b idle: got %h expected %h", obs, ev(1'b0, 1'b0, 2'd0));
        else passed++;
        cyc();
        for (int r = 0; r < 4; r++) begin
            owner = (r % 2 == 0) ? 2'd0 : 2'd1;
            for (int b = 0; b < B; b++) begin
                #1;
                total++;
                if (obs !== ev(1'b1, 1'b1, owner))
                    $display("FAIL b2b round %0d beat %0d: got %h expected %h", r, b, obs, ev(1'b1, 1'b1, owner));
                else passed++;
                cyc();
            end
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] order [6];
        order = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        do_reset();
        req = 4'b1011;
        #1;
        total++;
        if (obs !== ev(1'b0, 1'b0, 2'd0))
            $display("FAIL rr idle: got %h expected %h", obs, ev(1'b0, 1'b0, 2'd0));
        else passed++;
        cyc();
        for (int r = 0; r < 6; r++) begin
            for (int b = 0; b < B; b++) begin
                #1;
                total++;
                if (obs !== ev(1'b1, 1'b1, order[r]))
                    $display("FAIL rr grant %0d beat %0d: got %h expected %h", r, b, obs, ev(1'b1, 1'b1, order[r]));
                else passed++;
                cyc();
            end
        end
    endtask

    task automatic test_full_stall;
        int p;
        p = (B >= 4) ? 2 : 0;
        do_reset();
        req = 4'b0100;
        #1;
        total++;
        if (obs !== ev(1'b0, 1'b0, 2'd0))
            $display("FAIL stall idle: got %h expected %h", obs, ev(1'b0, 1'b0, 2'd0));
        else passed++;
        cyc();
        req = 4'b0101;
        for (int i = 0; i < p; i++) begin
            #1;
            total++;
            if (obs !== ev(1'b1, 1'b1, 2'd2))
                $display("FAIL stall pre beat %0d: got %h expected %h", i, obs, ev(1'b1, 1'b1, 2'd2));
            else passed++;
            cyc();
        end
        full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            total++;
            if (obs !== ev(1'b1, 1'b0, 2'd2))
                $display("FAIL stall full cycle %0d: got %h expected %h", s, obs, ev(1'b1, 1'b0, 2'd2));
            else passed++;
            cyc();
        end
        full = 1'b0;
        for (int i = 0; i < B - p; i++) begin
            #1;
            total++;
            if (obs !== ev(1'b1, 1'b1, 2'd2))
                $display("FAIL stall post beat %0d: got %h expected %h", i, obs, ev(1'b1, 1'b1, 2'd2));
            else passed++;
            cyc();
        end
        #1;
        total++;
        if (obs !== ev(1'b1, 1'b1, 2'd0))
            $display("FAIL stall next owner: got %h expected %h", obs, ev(1'b1, 1'b1, 2'd0));
        else passed++;
    endtask

    task automatic test_early_drop;
        logic [15:0] exp_drop;
        exp_drop = (B > 1) ? ev(1'b1, 1'b0, 2'd1) : ev(1'b1, 1'b1, 2'd3);
        do_reset();
        req = 4'b0010;
        #1;
        total++;
        if (obs !== ev(1'b0, 1'b0, 2'd0))
            $display("FAIL drop idle: got %h expected %h", obs, ev(1'b0, 1'b0, 2'd0));
        else passed++;
        cyc();
        req = 4'b1010;
        #1;
        total++;
        if (obs !== ev(1'b1, 1'b1, 2'd1))
            $display("FAIL drop first beat: got %h expected %h", obs, ev(1'b1, 1'b1, 2'd1));
        else passed++;
        cyc();
        req = 4'b1000;
        #1;
        total++;
        if (obs !== exp_drop)
            $display("FAIL drop cycle: got %h expected %h", obs, exp_drop);
        else passed++;
        cyc();
        #1;
        total++;
        if (obs !== ev(1'b1, 1'b1, 2'd3))
            $display("FAIL drop next owner: got %h expected %h", obs, ev(1'b1, 1'b1, 2'd3));
        else passed++;
    endtask

    task automatic test_mid_reset;
        logic [15:0] exp_rst;
        exp_rst = ev(1'b1, 1'b0, (B > 1) ? 2'd0 : 2'd1);
        do_reset();
        req = 4'b0011;
        #1;
        total++;
        if (obs !== ev(1'b0, 1'b0, 2'd0))
            $display("FAIL midrst idle: got %h expected %h", obs, ev(1'b0, 1'b0, 2'd0));
        else passed++;
        cyc();
        #1;
        total++;
        if (obs !== ev(1'b1, 1'b1, 2'd0))
            $display("FAIL midrst beat1: got %h expected %h", obs, ev(1'b1, 1'b1, 2'd0));
        else passed++;
        cyc();
        rst = 1'b0;
        #1;
        total++;
        if (obs !== exp_rst)
            $display("FAIL midrst reset cycle: got %h expected %h", obs, exp_rst);
        else passed++;
        cyc();
        rst = 1'b1;
        #1;
        total++;
        if (obs !== ev(1'b0, 1'b0, 2'd0))
            $display("FAIL midrst post reset: got %h expected %h", obs, ev(1'b0, 1'b0, 2'd0));
        else passed++;
        cyc();
        #1;
        total++;
        if (obs !== ev(1'b1, 1'b1, 2'd0))
            $display("FAIL midrst first grant: got %h expected %h", obs, ev(1'b1, 1'b1, 2'd0));
        else passed++;
    endtask

    initial begin
        rst      = 1'b0;
        req      = 4'b0000;
        full     = 1'b0;
        req_data = 32'hD3C2B1A0;
        test_reset();
        test_burst_sole();
        test_back_to_back();
        test_round_robin();
        test_full_stall();
        test_early_drop();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, FIFO write data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, the maximum beats per grant (1..16).
REQ-004 SHALL have port wr_clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port wr_rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester write request, level, held until acked.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port ack  output  NUM_REQ  one-hot pulse; the beat from requester i is written this cycle.
REQ-009 SHALL have port fifo_full  input  1  full flag from the async FIFO write side.
REQ-010 SHALL have port fifo_wr_en  output  1  FIFO write enable.
REQ-011 SHALL have port fifo_wr_data  output  DATA_WIDTH  FIFO write data.
REQ-012 SHALL have port grant_id  output  clog2(NUM_REQ)  current owner index, registered.
REQ-013 SHALL have port busy  output  1  high while the FSM is in GRANT.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and GRANT, with grant_id, last_grant and beat_cnt registered.
REQ-015 In IDLE, if any req is high, the FSM SHALL pick the first requesting index searching upward from last_grant+1 (mod NUM_REQ), load grant_id and enter GRANT next cycle; IDLE issues no writes.
REQ-016 In GRANT, fifo_wr_en and ack[grant_id] SHALL be combinational: high iff req[grant_id] && !fifo_full; fifo_wr_data SHALL equal req_data slice grant_id (zero-latency beat).
REQ-017 Each accepted beat SHALL increment beat_cnt (width clog2(MAX_BURST+1)); beat_cnt SHALL never exceed MAX_BURST.
REQ-018 Grant SHALL release when an accepted beat brings beat_cnt to MAX_BURST, or when req[grant_id] is low; on release last_grant <= grant_id and beat_cnt <= 0.
REQ-019 On release, if any req is high, the FSM SHALL stay in GRANT with the next round-robin winner (from the released index+1, current index eligible only if it is the sole requester), with no idle cycle; otherwise it SHALL go to IDLE.
REQ-020 While fifo_full is high in GRANT, the FSM SHALL hold grant_id and beat_cnt, assert no ack, and never release on full alone.
REQ-021 Requests from non-owners SHALL never receive ack; at most one ack bit SHALL be high per cycle.
REQ-022 A requester dropping req mid-burst SHALL be treated as a release in that same cycle (no write issued).

Reset
REQ-023 While wr_rst is low at a clock edge: state IDLE, grant_id 0, last_grant NUM_REQ-1 (requester 0 first), beat_cnt 0; hence fifo_wr_en 0, ack 0, busy 0.
REQ-024 Reset asserted mid-burst SHALL abort the grant without a partial-beat write in the reset cycle.

Configuration
REQ-025 Macro FIFO_WR_ARB_BURST_EN: when defined, burst length is MAX_BURST per REQ-017/018.
REQ-026 When FIFO_WR_ARB_BURST_EN is undefined, every grant SHALL release after exactly one accepted beat (pure per-beat round robin), beat_cnt SHALL be omitted and MAX_BURST ignored.

Structure
REQ-027 Shared package fifo_arb_pkg SHALL hold the FSM state enum and the clog2-derived width constants.
REQ-028 Sub-module rr_pick (combinational round-robin picker: req vector, last index in; valid, winner index out) SHALL be used for REQ-015 and REQ-019.

Verification
REQ-029 Reset: wr_rst low 3 cycles with req=4'b1111 -> fifo_wr_en 0, ack 0, busy 0, grant_id 0 throughout.
REQ-030 Burst: req=4'b0001 held, full=0, MAX_BURST=4 -> 1 IDLE cycle, then exactly 4 acks to requester 0, data matching req_data[7:0] each beat, then regrant to 0 back-to-back.
REQ-031 Round robin: req=4'b1011 held, BURST_EN undefined -> grant order 0,1,3,0,1,3, one beat each, no idle gaps.
REQ-032 Full stall: owner 2 mid-burst after 2 beats, fifo_full high 5 cycles -> no acks, grant_id stays 2, then 2 remaining beats on deassert.
REQ-033 Early drop: owner 1 drops req after 1 beat with req[3] high -> same cycle no write, next cycle grant_id 3, ack[3].
REQ-034 Mid-burst reset: wr_rst low during owner 0 beat 2 -> next cycle IDLE, grant_id 0, last_grant 3, first post-reset grant to 0.
